// File: rtl/de2_115_sopc_led_pio_out_pkg.sv
// de2_115_sopc_pio_pkg: register map and pulse-channel state shared by the SOPC PIO blocks
//   ADDR_*      word addresses of the PIO registers
//   ch_state_e  pulse channel state (idle / pulse running)
package de2_115_sopc_pio_pkg;
    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_PULSE_LEN = 3'd1;
    localparam logic [2:0] ADDR_TRIG      = 3'd2;
    localparam logic [2:0] ADDR_RSVD      = 3'd3;
    localparam logic [2:0] ADDR_OUTSET    = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR    = 3'd5;
    localparam logic [2:0] ADDR_DONE      = 3'd6;
    localparam logic [2:0] ADDR_IRQ_MASK  = 3'd7;
    typedef enum logic {CH_IDLE, CH_ACTIVE} ch_state_e;
endpackage

// File: rtl/de2_115_sopc_led_pio_out_if.sv
// de2_115_sopc_led_pio_out_if: Avalon-MM slave bus bundle for the LED output PIO
//   address     word address
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    registered read data from the slave
interface de2_115_sopc_led_pio_out_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport master(output address, chipselect, write_n, writedata, input readdata);
    modport slave(input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/de2_115_sopc_led_pio_out_pulse_channel.sv
// pio_pulse_channel: one-bit one-shot pulse timer of programmable length
//   clk, reset_n   clock, asynchronous active-low reset
//   trig_i         start (or restart) a pulse this cycle
//   len_i          pulse length in cycles, 0 behaves as 1
//   active_o       pulse currently running
//   done_pulse_o   one-cycle strobe when a pulse runs to completion
module pio_pulse_channel
    import de2_115_sopc_pio_pkg::*;
#(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             trig_i,
    input  logic [CNT_W-1:0] len_i,
    output logic             active_o,
    output logic             done_pulse_o
);
    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, load;
    assign load     = (len_i == '0) ? CNT_W'(1) : len_i;
    assign active_o = state_q == CH_ACTIVE;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CH_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    // a trigger always wins, so a retrigger or a trigger landing on the final count suppresses done
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        done_pulse_o = 1'b0;
        if (trig_i) begin
            state_d = CH_ACTIVE;
            cnt_d   = load;
        end else if (state_q == CH_ACTIVE) begin
            state_d      = (cnt_q == CNT_W'(1)) ? CH_IDLE : CH_ACTIVE;
            cnt_d        = cnt_q - CNT_W'(1);
            done_pulse_o = cnt_q == CNT_W'(1);
        end
    end
endmodule

// File: rtl/de2_115_sopc_led_pio_out.sv
// de2_115_sopc_led_pio_out: Avalon-MM output PIO with set/clear writes, per-bit one-shot pulses and done irq
//   clk, reset_n   clock, asynchronous active-low reset
//   avs            Avalon-MM slave bus (address/chipselect/write_n/writedata/readdata)
//   out_port_o     registered output pins, DATA with running pulses inverted
//   irq_o          level irq, |(DONE & IRQ_MASK)
module de2_115_sopc_led_pio_out
    import de2_115_sopc_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               CNT_W       = 24,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    de2_115_sopc_led_pio_out_if.slave    avs,
    output logic [WIDTH-1:0]             out_port_o,
    output logic                         irq_o
);
    logic             wr;
    logic [WIDTH-1:0] wd, trig, active, done_set;
    logic [WIDTH-1:0] data_q, data_d, done_q, done_d, mask_q, mask_d, out_q, out_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [31:0]      rd_q, rd_d;
    assign wr   = avs.chipselect & ~avs.write_n;
    assign wd   = avs.writedata[WIDTH-1:0];
    assign trig = (wr && avs.address == ADDR_TRIG) ? wd : '0;
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        pio_pulse_channel #(.CNT_W(CNT_W)) u_ch (
            .clk          (clk),
            .reset_n      (reset_n),
            .trig_i       (trig[i]),
            .len_i        (len_q),
            .active_o     (active[i]),
            .done_pulse_o (done_set[i])
        );
    end
    always_comb begin
        data_d = !wr                        ? data_q :
                 avs.address == ADDR_DATA   ? wd :
                 avs.address == ADDR_OUTSET ? data_q | wd :
                 avs.address == ADDR_OUTCLR ? data_q & ~wd : data_q;
        len_d  = (wr && avs.address == ADDR_PULSE_LEN) ? avs.writedata[CNT_W-1:0] : len_q;
        mask_d = (wr && avs.address == ADDR_IRQ_MASK) ? wd : mask_q;
        // a completion in the same cycle as its W1C leaves the bit set
        done_d = ((wr && avs.address == ADDR_DONE) ? done_q & ~wd : done_q) | done_set;
        out_d  = data_q ^ active;
        case (avs.address)
            ADDR_DATA:      rd_d = 32'(data_q);
            ADDR_PULSE_LEN: rd_d = 32'(len_q);
            ADDR_TRIG:      rd_d = 32'(active);
            ADDR_DONE:      rd_d = 32'(done_q);
            ADDR_IRQ_MASK:  rd_d = 32'(mask_q);
            default:        rd_d = '0;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE;
            out_q  <= RESET_VALUE;
            len_q  <= '0;
            done_q <= '0;
            mask_q <= '0;
            rd_q   <= '0;
        end else begin
            data_q <= data_d;
            out_q  <= out_d;
            len_q  <= len_d;
            done_q <= done_d;
            mask_q <= mask_d;
            rd_q   <= rd_d;
        end
    end
    assign avs.readdata = rd_q;
    assign out_port_o   = out_q;
    assign irq_o        = |(done_q & mask_q);
endmodule

// File: tb/tb_de2_115_sopc_led_pio_out.sv
// tb_de2_115_sopc_led_pio_out: directed and random bus traffic against a timestamp-based reference model
module tb_de2_115_sopc_led_pio_out;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] out_port;
    logic       irq;
    int         n_chk = 0;
    int         n_pass = 0;
    logic [7:0]  m_data, m_mask, m_done, m_act;
    logic [23:0] m_len;
    longint      m_end[8];
    longint      m_n;
    de2_115_sopc_led_pio_out_if bus();
    de2_115_sopc_led_pio_out #(.WIDTH(8), .CNT_W(24), .RESET_VALUE(8'hA5)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .avs        (bus),
        .out_port_o (out_port),
        .irq_o      (irq)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    task automatic m_reset();
        m_data = 8'hA5; m_mask = '0; m_done = '0; m_act = '0; m_len = '0; m_n = 0;
        for (int i = 0; i < 8; i++) m_end[i] = 0;
    endtask
    // model: a pulse triggered at edge n is live for edges n..n+L-1 and completes at edge n+L
    task automatic step(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] wd);
        logic       we;
        logic [7:0] trig, set, w8, exp_out;
        logic [31:0] exp_rd;
        @(negedge clk);
        bus.address = a; bus.chipselect = cs; bus.write_n = wn; bus.writedata = wd;
        @(posedge clk);
        m_n++;
        we = cs & ~wn;
        w8 = wd[7:0];
        exp_out = m_data ^ m_act;
        case (a)
            3'd0: exp_rd = {24'd0, m_data};
            3'd1: exp_rd = {8'd0, m_len};
            3'd2: exp_rd = {24'd0, m_act};
            3'd6: exp_rd = {24'd0, m_done};
            3'd7: exp_rd = {24'd0, m_mask};
            default: exp_rd = 0;
        endcase
        trig = (we && a == 3'd2) ? w8 : 8'd0;
        set = '0;
        for (int i = 0; i < 8; i++) begin
            if (m_end[i] == m_n && !trig[i]) set[i] = 1'b1;
            if (trig[i]) m_end[i] = m_n + ((m_len == 0) ? 1 : longint'(m_len));
        end
        if (we) begin
            case (a)
                3'd0: m_data = w8;
                3'd1: m_len = wd[23:0];
                3'd4: m_data = m_data | w8;
                3'd5: m_data = m_data & ~w8;
                3'd6: m_done = m_done & ~w8;
                3'd7: m_mask = w8;
                default: ;
            endcase
        end
        m_done = m_done | set;
        for (int i = 0; i < 8; i++) m_act[i] = m_n < m_end[i];
        #1;
        check("out_port", {24'd0, out_port}, {24'd0, exp_out});
        check("readdata", bus.readdata, exp_rd);
        check("irq", {31'd0, irq}, {31'd0, |(m_done & m_mask)});
    endtask
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        step(a, 1'b1, 1'b0, d);
    endtask
    task automatic rd(input logic [2:0] a);
        step(a, 1'b1, 1'b1, 32'd0);
    endtask
    initial begin
        int hi;
        reset_n = 1'b0;
        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        m_reset();
        repeat (3) @(negedge clk);
        check("rst_out", {24'd0, out_port}, 32'hA5);
        check("rst_rd", bus.readdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        reset_n = 1'b1;
        rd(3'd0);
        check("rd_data_reset", bus.readdata, 32'hA5);
        wr(3'd0, 32'h0F); wr(3'd4, 32'h30);
        check("outset", {24'd0, out_port}, 32'h0F);
        wr(3'd5, 32'h03);
        check("outclr_prev", {24'd0, out_port}, 32'h3F);
        rd(3'd3);
        check("outclr", {24'd0, out_port}, 32'h3C);
        wr(3'd1, 32'd5); wr(3'd0, 32'h00); wr(3'd2, 32'h01);
        hi = 0;
        for (int k = 0; k < 8; k++) begin rd(3'd6); hi += int'(out_port[0]); end
        check("pulse5_len", hi, 5);
        check("done0", bus.readdata, 32'h01);
        check("irq_masked", {31'd0, irq}, 32'd0);
        wr(3'd7, 32'h01);
        check("irq_on", {31'd0, irq}, 32'd1);
        wr(3'd6, 32'h01);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        wr(3'd1, 32'd0); wr(3'd2, 32'h80);
        hi = 0;
        for (int k = 0; k < 4; k++) begin rd(3'd6); hi += int'(out_port[7]); end
        check("pulse0_len", hi, 1);
        check("done7", {31'd0, bus.readdata[7]}, 32'd1);
        wr(3'd6, 32'hFF); wr(3'd1, 32'd4); wr(3'd2, 32'h02);
        hi = 0;
        rd(3'd3); hi += int'(out_port[1]);
        wr(3'd2, 32'h02); hi += int'(out_port[1]);
        for (int k = 0; k < 3; k++) begin rd(3'd6); hi += int'(out_port[1]); end
        check("retrig_no_done", {31'd0, bus.readdata[1]}, 32'd0);
        for (int k = 0; k < 5; k++) begin rd(3'd6); hi += int'(out_port[1]); end
        check("retrig_len", hi, 6);
        check("retrig_done", {31'd0, bus.readdata[1]}, 32'd1);
        wr(3'd1, 32'd2); wr(3'd2, 32'h04); rd(3'd3); wr(3'd6, 32'h04);
        rd(3'd6);
        check("w1c_set_wins", {31'd0, bus.readdata[2]}, 32'd1);
        wr(3'd1, 32'd100); wr(3'd2, 32'h10);
        repeat (5) rd(3'd2);
        check("long_pulse_on", {31'd0, out_port[4]}, 32'd1);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("async_rst_out", {24'd0, out_port}, 32'hA5);
        check("async_rst_rd", bus.readdata, 32'd0);
        check("async_rst_irq", {31'd0, irq}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m_reset();
        rd(3'd2); rd(3'd3);
        check("trig_after_rst", bus.readdata, 32'd0);
        repeat (110) rd(3'd6);
        check("no_done_after_rst", bus.readdata, 32'd0);
        for (int k = 0; k < 1500; k++) begin
            logic [2:0] a;
            a = 3'($urandom_range(0, 7));
            step(a, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 (a == 3'd1) ? 32'($urandom_range(0, 6)) : $urandom);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
